// File: rtl/sync_fifo_prog_pkg.sv
// Shared definitions for sync_fifo_prog: read-mode encodings and width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sync_fifo_prog_pkg;

    // Read-mode selector values for the FWFT parameter
    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Width of count/threshold fields: must hold the value DEPTH itself
    function automatic int cw_of(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_fifo_mem.sv
// fifo_mem: WIDTH x DEPTH storage, registered write port, combinational read port.
// Latency: a write lands on the clock edge; the read port reflects it from the next cycle.
// Backpressure: none, the caller decides when a write is legal.
module fifo_mem
    import sync_fifo_prog_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = cw_of(DEPTH) - 1
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_dat
);

    // Contents are intentionally not reset; validity is tracked by the FIFO count
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: store data on an accepted push
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO, standard or FWFT read, programmable almost flags, sticky errors.
// Latency: write visible at the read side next cycle; standard mode rd_data updates the cycle after pop.
// Backpressure: push while full (without pop) and pop while empty are dropped and flagged. SYNC_FIFO_HWM_EN adds hwm/hwm_clr.
module sync_fifo_prog
    import sync_fifo_prog_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    parameter  int FWFT  = MODE_STD,
    localparam int CW    = cw_of(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    input  logic [CW-1:0]    af_thresh,
    input  logic [CW-1:0]    ae_thresh,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
`ifdef SYNC_FIFO_HWM_EN
    input  logic             hwm_clr,
    output logic [CW-1:0]    hwm,
`endif
    input  logic             err_clr
);

    localparam int AW = CW - 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_prog: DEPTH must be a power of two >= 2");
    end
    if (FWFT != MODE_STD && FWFT != MODE_FWFT) begin : g_bad_mode
        $error("sync_fifo_prog: FWFT must be 0 or 1");
    end

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [WIDTH-1:0] w_mem_rd;

    // Flags derive from the registered count, so threshold edits act immediately
    assign full         = (r_count == CW'(DEPTH));
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= af_thresh);
    assign almost_empty = (r_count <= ae_thresh);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A pop frees a slot in the same cycle, so push is legal on full when paired with pop
    assign w_push_ok = push & (~full | pop);
    assign w_pop_ok  = pop & ~empty;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push_ok),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_dat  (w_mem_rd)
    );

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

    // Sticky error flags: a new error in the clear cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push & full & ~pop) r_overflow <= 1'b1;
            else if (err_clr)       r_overflow <= 1'b0;
            if (pop & empty)        r_underflow <= 1'b1;
            else if (err_clr)       r_underflow <= 1'b0;
        end
    end

    if (FWFT == MODE_FWFT) begin : g_fwft
        // Head entry drives the output directly; meaningless while empty
        assign rd_data = w_mem_rd;
    end else begin : g_std
        logic [WIDTH-1:0] r_rd_data;

        // Registered read: capture the head on an accepted pop, hold otherwise
        always_ff @(posedge clk) begin
            if (rst)           r_rd_data <= '0;
            else if (w_pop_ok) r_rd_data <= w_mem_rd;
        end

        assign rd_data = r_rd_data;
    end

`ifdef SYNC_FIFO_HWM_EN
    logic [CW-1:0] r_hwm;

    // High-water mark follows the registered count, one cycle behind it
    always_ff @(posedge clk) begin
        if (rst)                  r_hwm <= '0;
        else if (hwm_clr)         r_hwm <= r_count;
        else if (r_count > r_hwm) r_hwm <= r_count;
    end

    assign hwm = r_hwm;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: standard and FWFT instances share one stimulus stream.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: the queue model decides which push/pop are accepted.
module tb_sync_fifo_prog;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             err_clr = 1'b0;
    logic             hwm_clr = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [CW-1:0]    af_thresh = 3'd4;
    logic [CW-1:0]    ae_thresh = 3'd0;

    logic [WIDTH-1:0] s_rd, f_rd;
    logic             s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic             f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [CW-1:0]    s_count, f_count;
`ifdef SYNC_FIFO_HWM_EN
    logic [CW-1:0]    s_hwm, f_hwm;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: plain queue plus sticky flags
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_rd_std = '0;
    logic             m_ovf = 1'b0;
    logic             m_udf = 1'b0;
    int               m_hwm = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .push(push), .wr_data(wr_data), .pop(pop),
        .rd_data(s_rd), .full(s_full), .empty(s_empty),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_udf),
`ifdef SYNC_FIFO_HWM_EN
        .hwm_clr(hwm_clr), .hwm(s_hwm),
`endif
        .err_clr(err_clr)
    );

    sync_fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .push(push), .wr_data(wr_data), .pop(pop),
        .rd_data(f_rd), .full(f_full), .empty(f_empty),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf),
`ifdef SYNC_FIFO_HWM_EN
        .hwm_clr(hwm_clr), .hwm(f_hwm),
`endif
        .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs held across the edge
    task automatic model_edge();
        int  c;
        bit  p_ok, o_ok;
        c    = q.size();
        p_ok = push && (c < DEPTH || pop);
        o_ok = pop && (c > 0);
        if (rst) begin
            q.delete();
            m_rd_std = '0;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
            m_hwm    = 0;
        end else begin
            if (hwm_clr)        m_hwm = c;
            else if (c > m_hwm) m_hwm = c;
            if (push && c == DEPTH && !pop) m_ovf = 1'b1;
            else if (err_clr)               m_ovf = 1'b0;
            if (pop && c == 0)              m_udf = 1'b1;
            else if (err_clr)               m_udf = 1'b0;
            if (o_ok) m_rd_std = q.pop_front();
            if (p_ok) q.push_back(wr_data);
        end
    endtask

    task automatic check_flags();
        int c;
        c = q.size();
        check("s_almost_full",  32'(s_af), 32'(c >= int'(af_thresh)));
        check("s_almost_empty", 32'(s_ae), 32'(c <= int'(ae_thresh)));
        check("f_almost_full",  32'(f_af), 32'(c >= int'(af_thresh)));
        check("f_almost_empty", 32'(f_ae), 32'(c <= int'(ae_thresh)));
    endtask

    task automatic check_all();
        int c;
        c = q.size();
        check("s_count",     32'(s_count), 32'(c));
        check("f_count",     32'(f_count), 32'(c));
        check("s_full",      32'(s_full),  32'(c == DEPTH));
        check("s_empty",     32'(s_empty), 32'(c == 0));
        check("f_full",      32'(f_full),  32'(c == DEPTH));
        check("f_empty",     32'(f_empty), 32'(c == 0));
        check("s_overflow",  32'(s_ovf),   32'(m_ovf));
        check("s_underflow", 32'(s_udf),   32'(m_udf));
        check("f_overflow",  32'(f_ovf),   32'(m_ovf));
        check("f_underflow", 32'(f_udf),   32'(m_udf));
        check("s_rd_data",   32'(s_rd),    32'(m_rd_std));
        if (c > 0) check("f_rd_data", 32'(f_rd), 32'(q[0]));
`ifdef SYNC_FIFO_HWM_EN
        check("s_hwm", 32'(s_hwm), 32'(m_hwm));
        check("f_hwm", 32'(f_hwm), 32'(m_hwm));
`endif
        check_flags();
    endtask

    // One clock with the given request mix; rst/hwm_clr/thresholds are set by the caller
    task automatic step(input logic p, input logic [WIDTH-1:0] d, input logic o, input logic ec);
        push    = p;
        wr_data = d;
        pop     = o;
        err_clr = ec;
        @(posedge clk);
        model_edge();
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        hwm_clr = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_empty", 32'(s_empty), 32'd1);
        check("rst_rd_data", 32'(s_rd), 32'd0);

        // Fill to full, then an overflowing push, then clear
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        check("dir_full", 32'(s_full), 32'd1);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        check("dir_overflow", 32'(s_ovf), 32'd1);
        check("dir_count_full", 32'(s_count), 32'd4);
        step(1'b0, '0, 1'b0, 1'b1);
        check("dir_ovf_clr", 32'(s_ovf), 32'd0);

        // Push and pop on full: count holds, head leaves, new tail wraps
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("dir_pp_rd", 32'(s_rd), 32'h11);
        check("dir_pp_count", 32'(s_count), 32'd4);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("dir_rd_44", 32'(s_rd), 32'h44);
        step(1'b0, '0, 1'b1, 1'b0);
        check("dir_rd_55", 32'(s_rd), 32'h55);
        check("dir_empty", 32'(s_empty), 32'd1);
        // Extra pop: dropped, underflow set, output holds
        step(1'b0, '0, 1'b1, 1'b0);
        check("dir_underflow", 32'(s_udf), 32'd1);
        check("dir_rd_hold", 32'(s_rd), 32'h55);
        step(1'b0, '0, 1'b0, 1'b1);

        // FWFT: first push visible without a pop
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("dir_fwft_rd", 32'(f_rd), 32'hA5);
        check("dir_fwft_nonempty", 32'(f_empty), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("dir_fwft_empty", 32'(f_empty), 32'd1);

        // Programmable thresholds; a threshold change acts without a clock
        af_thresh = 3'd3;
        ae_thresh = 3'd1;
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        check("dir_ae_at2", 32'(s_ae), 32'd0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        check("dir_af_at3", 32'(s_af), 32'd1);
        af_thresh = 3'd4;
        #1;
        check("dir_af_thresh4", 32'(s_af), 32'd0);
        check_flags();

        // Mid-operation reset with a push pending: everything discarded
        rst = 1'b1;
        step(1'b1, 8'h77, 1'b0, 1'b0);
        rst = 1'b0;
        check("dir_rst_count", 32'(s_count), 32'd0);

        // Push and pop on empty: push accepted, pop dropped, underflow set
        step(1'b1, 8'h66, 1'b1, 1'b0);
        check("dir_pp_empty_cnt", 32'(s_count), 32'd1);
        check("dir_pp_empty_udf", 32'(s_udf), 32'd1);
        // Error set coinciding with err_clr: set wins
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        check("dir_set_wins", 32'(s_udf), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);

        // High-water mark sequence (checked through the model when enabled)
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        hwm_clr = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 8'hD1, 1'b0, 1'b0);
        step(1'b1, 8'hD2, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;

        // Randomized traffic, thresholds, clears and occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                af_thresh = CW'($urandom_range(0, 7));
                ae_thresh = CW'($urandom_range(0, 7));
                #1;
                check_flags();
            end
            rst     = ($urandom_range(0, 79) == 0);
            hwm_clr = ($urandom_range(0, 23) == 0);
            step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 11) == 0));
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
